// File: rtl/receiver_module.sv
// UART 8N1 receiver: 2-FF synchronised RxD, mid-bit sampling, one-cycle valid/frame_error strobes.
// Optional even-parity bit when RX_PARITY_EN is defined (11-bit frames instead of 10).
module receiver_module #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       frame_error,
    output logic       parity_error,
    output logic [2:0] dbg_state_o
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      index_q, index_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            rx_s;
    logic            timer_last;
`ifdef RX_PARITY_EN
    logic            perr_q, perr_d;
    logic            par_bad_q, par_bad_d;
`endif

    assign rx_s       = sync_q[1];
    assign timer_last = (timer_q == T_LAST);

    // Output strobes: valid marks the single cycle data changes; there is no
    // back-pressure, so a consumer that misses the strobe loses that byte.
    assign data         = data_q;
    assign valid        = valid_q;
    assign frame_error  = ferr_q;
    assign busy         = (state_q != S_IDLE);
    assign dbg_state_o  = state_q;
`ifdef RX_PARITY_EN
    assign parity_error = perr_q;
`else
    assign parity_error = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        index_d = index_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                index_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (timer_q == T_HALF) begin
                    timer_d = '0;
                    index_d = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DATA: begin
                timer_d = timer_last ? '0 : timer_q + TW'(1);
                if (timer_last) begin
                    shift_d[index_q] = rx_s;
                    index_d = index_q + 3'd1;
`ifdef RX_PARITY_EN
                    if (index_q == 3'd7) state_d = S_PARITY;
`else
                    if (index_q == 3'd7) state_d = S_STOP;
`endif
                end
            end
`ifdef RX_PARITY_EN
            S_PARITY: begin
                timer_d = timer_last ? '0 : timer_q + TW'(1);
                if (timer_last) begin
                    par_bad_d = rx_s ^ (^shift_q);
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                timer_d = timer_last ? '0 : timer_q + TW'(1);
                if (timer_last) begin
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
`ifdef RX_PARITY_EN
                        perr_d  = par_bad_q;
`endif
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // Line held low (break): wait for idle before hunting for a new start bit.
                timer_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                index_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sync_q  <= 2'b11;
            timer_q <= '0;
            index_q <= '0;
            shift_q <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], RxD};
            timer_q <= timer_d;
            index_q <= index_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end
endmodule

// File: tb/tb_receiver_module.sv
// Bench for receiver_module: serial frame driver, timed expectation queue, per-cycle compare.
module tb_receiver_module;
    localparam int CPB = 16;
`ifdef RX_PARITY_EN
    localparam int PRE_STOP_BITS = 10;
`else
    localparam int PRE_STOP_BITS = 9;
`endif
    // Stop bit sampled at its middle, plus 2 sync cycles and 1 cycle to the registered strobe.
    localparam int OFF = PRE_STOP_BITS * CPB + CPB / 2 + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RxD;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_error;
    logic       parity_error;
    logic [2:0] dbg_state;

    receiver_module #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .RxD          (RxD),
        .data         (data),
        .valid        (valid),
        .busy         (busy),
        .frame_error  (frame_error),
        .parity_error (parity_error),
        .dbg_state_o  (dbg_state)
    );

    // ---- clock / cycle counter ----
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---- checking bookkeeping ----
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // ---- model: each sent frame yields one timed event ----
    typedef struct packed {
        logic [31:0] cyc;
        logic        fe;
        logic        pe;
        logic [7:0]  d;
    } exp_t;
    exp_t       exp_q[$];
    logic [7:0] model_data = 8'h00;

    always @(negedge clk) begin
        exp_t e;
        logic exp_v, exp_fe, exp_pe;
        if (!rst_n) begin
            exp_q.delete();
            model_data = 8'h00;
            check("rst_data", {24'd0, data}, 32'h0);
            check("rst_valid", {31'd0, valid}, 32'h0);
            check("rst_busy", {31'd0, busy}, 32'h0);
            check("rst_frame_error", {31'd0, frame_error}, 32'h0);
            check("rst_parity_error", {31'd0, parity_error}, 32'h0);
        end else begin
            exp_v = 1'b0; exp_fe = 1'b0; exp_pe = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                if (e.fe) exp_fe = 1'b1;
                else begin
                    exp_v = 1'b1;
                    exp_pe = e.pe;
                    model_data = e.d;
                end
            end
            check("valid", {31'd0, valid}, {31'd0, exp_v});
            check("frame_error", {31'd0, frame_error}, {31'd0, exp_fe});
            check("parity_error", {31'd0, parity_error}, {31'd0, exp_pe});
            check("data", {24'd0, data}, {24'd0, model_data});
        end
    end

    // ---- strobe watcher for hand-computed expectations ----
    int         valid_cnt = 0;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    int         last_valid_cyc = 0;
    logic [7:0] last_data = 8'h00;
    always @(negedge clk) begin
        if (rst_n && valid) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
            last_data      <= data;
        end
        if (rst_n && frame_error) fe_cnt <= fe_cnt + 1;
        if (rst_n && parity_error) pe_cnt <= pe_cnt + 1;
    end

    // ---- driver tasks (all stimulus changes land 1 time unit after a rising edge) ----
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                              output int st);
        exp_t e;
        RxD = 1'b0;
        st  = cyc;
        e.cyc = st + OFF;
        e.fe  = ~stop_bit;
        e.pe  = stop_bit & par_flip;
        e.d   = b;
        exp_q.push_back(e);
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            tick(CPB);
        end
`ifdef RX_PARITY_EN
        RxD = (^b) ^ par_flip;
        tick(CPB);
`endif
        RxD = stop_bit;
        tick(CPB);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---- directed sequence ----
    initial begin
        int st, v0, f0;
        rst_n = 1'b0;
        RxD   = 1'b1;
        tick(5);
        rst_n = 1'b1;
        tick(CPB);

        // 1: single byte, exact latency
        v0 = valid_cnt; f0 = fe_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, st);
        tick(CPB);
`ifdef RX_PARITY_EN
        check("t1_latency", last_valid_cyc - st, 171);
`else
        check("t1_latency", last_valid_cyc - st, 155);
`endif
        check("t1_data", {24'd0, last_data}, 32'hA5);
        check("t1_valid_count", valid_cnt - v0, 1);
        check("t1_no_frame_error", fe_cnt - f0, 0);

        // 2: quarter-bit glitch is a false start
        v0 = valid_cnt; f0 = fe_cnt;
        RxD = 1'b0;
        tick(4);
        check("t2_busy_in_glitch", {31'd0, busy}, 32'h1);
        RxD = 1'b1;
        tick(9);
        check("t2_busy_dropped", {31'd0, busy}, 32'h0);
        tick(CPB);
        check("t2_no_valid", valid_cnt - v0, 0);
        check("t2_no_frame_error", fe_cnt - f0, 0);

        // 3: bad stop bit, line held low, then recovery
        v0 = valid_cnt; f0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, st);
        tick(24);
        check("t3_busy_while_low", {31'd0, busy}, 32'h1);
        check("t3_frame_error_count", fe_cnt - f0, 1);
        check("t3_no_valid", valid_cnt - v0, 0);
        RxD = 1'b1;
        tick(4);
        check("t3_busy_after_high", {31'd0, busy}, 32'h0);
        tick(CPB);
        send_frame(8'h81, 1'b1, 1'b0, st);
        tick(CPB);
        check("t3_recover_data", {24'd0, last_data}, 32'h81);

        // 4: back-to-back frames, no idle gap
        v0 = valid_cnt;
        send_frame(8'h00, 1'b1, 1'b0, st);
        send_frame(8'hFF, 1'b1, 1'b0, st);
        send_frame(8'h55, 1'b1, 1'b0, st);
        tick(CPB);
        check("t4_valid_count", valid_cnt - v0, 3);
        check("t4_last_data", {24'd0, last_data}, 32'h55);

        // 5: reset during bit 4 of 8'hC3
        v0 = valid_cnt;
        RxD = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            RxD = 8'hC3 >> i;
            tick(CPB);
        end
        RxD = 1'b0;
        tick(CPB / 2);
        check("t5_busy_before_reset", {31'd0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_data", {24'd0, data}, 32'h0);
        check("t5_rst_valid", {31'd0, valid}, 32'h0);
        check("t5_rst_busy", {31'd0, busy}, 32'h0);
        check("t5_rst_frame_error", {31'd0, frame_error}, 32'h0);
        RxD = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(2 * CPB);
        check("t5_no_valid_from_partial", valid_cnt - v0, 0);
        send_frame(8'h12, 1'b1, 1'b0, st);
        tick(CPB);
        check("t5_after_reset_data", {24'd0, last_data}, 32'h12);

`ifdef RX_PARITY_EN
        // 6: parity good then bad; byte delivered either way
        v0 = valid_cnt;
        f0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b0, st);
        tick(CPB);
        check("t6_good_parity_no_error", pe_cnt - f0, 0);
        send_frame(8'h07, 1'b1, 1'b1, st);
        tick(CPB);
        check("t6_bad_parity_error", pe_cnt - f0, 1);
        check("t6_valid_count", valid_cnt - v0, 2);
`endif

        tick(CPB);
        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
